// File: rtl/main_pkg.sv
// +----------------------------------------------------------------------------+
// | main_pkg: shared types and constants for the in-memory bubble sorter.     |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package main_pkg;

    localparam int NUM_ELEMS  = 100;
    localparam int WORD_W     = 32;
    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 64;
    localparam int SIZE_W     = 7;
    localparam int IDX_W      = 7;
    localparam int DEF_BASE   = 256;
    localparam int LEGAL_SIZE = 32;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_INIT     = 3'd1,
        S_CMP      = 3'd2,
        S_PASS_END = 3'd3,
        S_DONE     = 3'd4
    } state_e;

endpackage

`default_nettype wire

// File: rtl/main_slave_port.sv
// +----------------------------------------------------------------------------+
// | main_slave_port: one slave channel - address decode, write strobe, and    |
// | registered acknowledge / read data lane.                                  |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module main_slave_port
    import main_pkg::*;
#(
    parameter int BASE = DEF_BASE
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              oe_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [SIZE_W-1:0] size_i,
    input  logic [WORD_W-1:0] rd_word_i,
    output logic              wr_o,
    output logic [IDX_W-1:0]  idx_o,
    output logic              rdy_o,
    output logic [DATA_W-1:0] rdata_o
);

    localparam logic [ADDR_W:0] BASE_X = (ADDR_W+1)'(BASE);
    localparam logic [ADDR_W:0] SPAN_X = (ADDR_W+1)'(NUM_ELEMS * 4);

    logic [ADDR_W:0]   w_addr_x;
    logic [ADDR_W:0]   w_off;
    logic              w_hit;
    logic              rdy_q;
    logic [DATA_W-1:0] rdata_q;

    assign w_addr_x = {1'b0, addr_i};
    assign w_off    = w_addr_x - BASE_X;
    assign w_hit    = (oe_i || we_i)
                   && (w_addr_x >= BASE_X) && (w_off < SPAN_X)
                   && (addr_i[1:0] == 2'b00)
                   && (size_i == SIZE_W'(LEGAL_SIZE));

    // Index is forced to 0 on a miss so the read mux never sees an out-of-array index.
    assign idx_o = w_hit ? w_off[IDX_W+1:2] : '0;
    assign wr_o  = w_hit && we_i;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            rdy_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            rdy_q   <= w_hit;
            rdata_q <= (w_hit && !we_i) ? DATA_W'(rd_word_i) : '0;
        end
    end

    assign rdy_o   = rdy_q;
    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/main.sv
// +----------------------------------------------------------------------------+
// | main: fills a 100-word array with a descending pattern and bubble-sorts   |
// | it ascending (signed), with two slave channels for array access.          |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module main
    import main_pkg::*;
#(
    parameter int MEM_var_26078_26084 = DEF_BASE
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start_port,
    input  logic [1:0]   S_oe_ram,
    input  logic [1:0]   S_we_ram,
    input  logic [19:0]  S_addr_ram,
    input  logic [127:0] S_Wdata_ram,
    input  logic [13:0]  S_data_ram_size,
    output logic         done_port,
    output logic [127:0] Sout_Rdata_ram,
    output logic [1:0]   Sout_DataRdy
);

    localparam logic [IDX_W-1:0] LAST_I   = IDX_W'(NUM_ELEMS - 1);
    localparam logic [IDX_W-1:0] LAST_CMP = IDX_W'(NUM_ELEMS - 2);

    state_e                   state_q, state_d;
    logic [IDX_W-1:0]         i_q, i_d;
    logic [IDX_W-1:0]         j_q, j_d;
    logic [IDX_W-1:0]         p_q, p_d;
    logic                     swap_q, swap_d;
    logic signed [WORD_W-1:0] mem_q [NUM_ELEMS];

    logic [IDX_W-1:0]         w_j1;
    logic signed [WORD_W-1:0] w_a, w_b, w_init_val;
    logic                     w_gt;
    logic [1:0]               w_wr;
    logic [IDX_W-1:0]         w_idx   [2];
    logic [WORD_W-1:0]        w_wdata [2];

    assign w_j1       = j_q + IDX_W'(1);
    assign w_a        = mem_q[j_q];
    assign w_b        = mem_q[w_j1];
    assign w_gt       = w_a > w_b;
    assign w_init_val = -(WORD_W'(i_q) + WORD_W'(1));
    assign done_port  = (state_q == S_DONE);

    genvar k;
    for (k = 0; k < 2; k++) begin : g_slave
        logic [WORD_W-1:0] w_unused_hi;
        assign w_wdata[k]  = S_Wdata_ram[DATA_W*k +: WORD_W];
        assign w_unused_hi = S_Wdata_ram[DATA_W*k+WORD_W +: WORD_W];

        main_slave_port #(
            .BASE(MEM_var_26078_26084)
        ) u_port (
            .clock_i  (clock),
            .reset_i  (reset),
            .oe_i     (S_oe_ram[k]),
            .we_i     (S_we_ram[k]),
            .addr_i   (S_addr_ram[ADDR_W*k +: ADDR_W]),
            .size_i   (S_data_ram_size[SIZE_W*k +: SIZE_W]),
            .rd_word_i(mem_q[w_idx[k]]),
            .wr_o     (w_wr[k]),
            .idx_o    (w_idx[k]),
            .rdy_o    (Sout_DataRdy[k]),
            .rdata_o  (Sout_Rdata_ram[DATA_W*k +: DATA_W])
        );
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        p_d     = p_q;
        swap_d  = swap_q;
        case (state_q)
            S_IDLE: begin
                if (start_port) begin
                    state_d = S_INIT;
                    i_d     = '0;
                end
            end
            S_INIT: begin
                i_d = i_q + IDX_W'(1);
                if (i_q == LAST_I) begin
                    state_d = S_CMP;
                    p_d     = '0;
                    j_d     = '0;
                    swap_d  = 1'b0;
                end
            end
            S_CMP: begin
                if (w_gt) begin
                    swap_d = 1'b1;
                end
                if (j_q == LAST_CMP - p_q) begin
                    state_d = S_PASS_END;
                end else begin
                    j_d = j_q + IDX_W'(1);
                end
            end
            S_PASS_END: begin
                if (!swap_q || p_q == LAST_CMP) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_CMP;
                    p_d     = p_q + IDX_W'(1);
                    j_d     = '0;
                    swap_d  = 1'b0;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            p_q     <= '0;
            swap_q  <= 1'b0;
            for (int n = 0; n < NUM_ELEMS; n++) begin
                mem_q[n] <= '0;
            end
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            p_q     <= p_d;
            swap_q  <= swap_d;
            case (state_q)
                S_INIT: mem_q[i_q] <= w_init_val;
                S_CMP: begin
                    if (w_gt) begin
                        mem_q[j_q]  <= w_b;
                        mem_q[w_j1] <= w_a;
                    end
                end
                // Slave writes land only while idle; later channel overrides on a collision.
                S_IDLE: begin
                    for (int c = 0; c < 2; c++) begin
                        if (w_wr[c]) begin
                            mem_q[w_idx[c]] <= w_wdata[c];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_main.sv
// +----------------------------------------------------------------------------+
// | tb_main: scoreboard bench for main - directed slave accesses and sort runs.|
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_main;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start_port = 1'b0;
    logic [1:0]   S_oe_ram = '0;
    logic [1:0]   S_we_ram = '0;
    logic [19:0]  S_addr_ram = '0;
    logic [127:0] S_Wdata_ram = '0;
    logic [13:0]  S_data_ram_size = '0;
    logic         done_port;
    logic [127:0] Sout_Rdata_ram;
    logic [1:0]   Sout_DataRdy;

    main #(
        .MEM_var_26078_26084(256)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .start_port     (start_port),
        .S_oe_ram       (S_oe_ram),
        .S_we_ram       (S_we_ram),
        .S_addr_ram     (S_addr_ram),
        .S_Wdata_ram    (S_Wdata_ram),
        .S_data_ram_size(S_data_ram_size),
        .done_port      (done_port),
        .Sout_Rdata_ram (Sout_Rdata_ram),
        .Sout_DataRdy   (Sout_DataRdy)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          due;
        int          ch;
        logic        rdy;
        logic        chk_data;
        logic [63:0] data;
        string       name;
    } exp_t;

    exp_t sq[$];
    int   done_q[$];
    int   cyc      = 0;
    int   errors   = 0;
    int   checks   = 0;
    int   spurious = 0;
    int   run_s    = 0;
    exp_t mon_e;
    bit [1:0] mon_seen;

    always @(posedge clock) cyc = cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations due this cycle; any other non-zero lane is spurious.
    always @(negedge clock) begin
        mon_seen = 2'b00;
        while (sq.size() > 0 && sq[0].due == cyc) begin
            mon_e = sq.pop_front();
            mon_seen[mon_e.ch] = 1'b1;
            check({mon_e.name, " rdy"}, 64'(Sout_DataRdy[mon_e.ch]), 64'(mon_e.rdy));
            if (mon_e.chk_data)
                check({mon_e.name, " data"}, Sout_Rdata_ram[64*mon_e.ch +: 64], mon_e.data);
        end
        for (int c = 0; c < 2; c++) begin
            if (!mon_seen[c] && (Sout_DataRdy[c] !== 1'b0 || Sout_Rdata_ram[64*c +: 64] !== 64'd0))
                spurious++;
        end
        if (done_port === 1'b1) begin
            if (done_q.size() > 0) check("done cycle", cyc, done_q.pop_front());
            else                   check("done pending count", done_q.size(), 1);
        end else if (done_q.size() > 0 && done_q[0] < cyc) begin
            check("done pulse missing", done_port, 1);
            void'(done_q.pop_front());
        end
    end

    task automatic set_lane(input int ch, input bit oe, input bit we, input int addr,
                            input logic [31:0] wd, input int size);
        S_oe_ram[ch]               = oe;
        S_we_ram[ch]               = we;
        S_addr_ram[10*ch +: 10]    = 10'(addr);
        S_Wdata_ram[64*ch +: 64]   = {32'hDEAD_BEEF, wd};
        S_data_ram_size[7*ch +: 7] = 7'(size);
    endtask

    task automatic clear_lanes();
        S_oe_ram = '0; S_we_ram = '0; S_addr_ram = '0; S_Wdata_ram = '0; S_data_ram_size = '0;
    endtask

    task automatic expect_lane(input int ch, input bit rdy, input bit chk,
                               input logic [31:0] d, input string name);
        exp_t e;
        e.due = cyc + 1; e.ch = ch; e.rdy = rdy; e.chk_data = chk;
        e.data = {32'd0, d}; e.name = name;
        sq.push_back(e);
    endtask

    task automatic slv1(input int ch, input bit oe, input bit we, input int addr,
                        input logic [31:0] wd, input int size, input bit rdy,
                        input bit chk, input logic [31:0] d, input string name);
        @(negedge clock);
        set_lane(ch, oe, we, addr, wd, size);
        expect_lane(ch, rdy, chk, d, name);
        @(negedge clock);
        clear_lanes();
    endtask

    // run_s is the cyc value seen in cycle 1, the cycle right after the sampling edge.
    task automatic start_run();
        @(negedge clock);
        start_port = 1'b1;
        run_s = cyc + 1;
        done_q.push_back(run_s + 5150 - 1);
        @(negedge clock);
        start_port = 1'b0;
    endtask

    task automatic wait_run_cycle(input int n);
        int guard = 0;
        while (cyc < run_s + n - 1 && guard < 10000) begin
            @(negedge clock);
            guard++;
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_q.size() > 0 && n < 6000) begin
            @(negedge clock);
            n++;
        end
        if (done_q.size() > 0) begin
            check("done timeout", done_q.size(), 0);
            done_q.delete();
        end
        @(negedge clock);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("reset done_port", done_port, 0);
        check("reset DataRdy", Sout_DataRdy, 0);
        check("reset Rdata lo", Sout_Rdata_ram[63:0], 0);
        check("reset Rdata hi", Sout_Rdata_ram[127:64], 0);
        reset = 1'b0;
        slv1(0, 1, 0, 256, 0, 32, 1, 1, 32'h0, "post-reset A[0]");

        // Run 1: busy write must be acked but dropped, second start ignored.
        start_run();
        wait_run_cycle(500);
        slv1(0, 0, 1, 256, 32'h1234, 32, 1, 0, 32'h0, "busy write ack");
        wait_run_cycle(1000);
        start_port = 1'b1;
        @(negedge clock);
        start_port = 1'b0;
        wait_done();

        slv1(0, 1, 0, 256, 0, 32, 1, 1, 32'hFFFF_FF9C, "A[0] sorted");
        slv1(0, 1, 0, 652, 0, 32, 1, 1, 32'hFFFF_FFFF, "A[99] sorted");
        slv1(1, 1, 0, 300, 0, 32, 1, 1, 32'hFFFF_FFA7, "ch1 A[11]");
        slv1(1, 0, 1, 260, 32'd5, 32, 1, 0, 32'h0, "ch1 write ack");
        slv1(1, 1, 0, 260, 0, 32, 1, 1, 32'h5, "ch1 readback");
        slv1(0, 1, 0, 656, 0, 32, 0, 1, 32'h0, "out of range");
        slv1(0, 1, 0, 257, 0, 32, 0, 1, 32'h0, "misaligned");
        slv1(0, 1, 0, 252, 0, 32, 0, 1, 32'h0, "below base");
        slv1(1, 1, 0, 256, 0, 16, 0, 1, 32'h0, "size 16");
        slv1(0, 1, 1, 264, 32'd77, 32, 1, 0, 32'h0, "oe+we ack");
        slv1(0, 1, 0, 264, 0, 32, 1, 1, 32'd77, "oe+we wrote");

        @(negedge clock);
        set_lane(0, 0, 1, 268, 32'd111, 32);
        set_lane(1, 0, 1, 268, 32'd222, 32);
        expect_lane(0, 1, 0, 32'h0, "dual write ch0 ack");
        expect_lane(1, 1, 0, 32'h0, "dual write ch1 ack");
        @(negedge clock);
        clear_lanes();
        slv1(0, 1, 0, 268, 0, 32, 1, 1, 32'd222, "ch1 wins collision");

        @(negedge clock);
        set_lane(0, 1, 0, 256, 0, 32);
        set_lane(1, 1, 0, 652, 0, 32);
        expect_lane(0, 1, 1, 32'hFFFF_FF9C, "dual read ch0");
        expect_lane(1, 1, 1, 32'hFFFF_FFFF, "dual read ch1");
        @(negedge clock);
        clear_lanes();

        // Run 2: aborted by reset, then rerun from scratch.
        start_run();
        wait_run_cycle(2000);
        reset = 1'b1;
        done_q.delete();
        repeat (2) @(negedge clock);
        check("mid-run reset done_port", done_port, 0);
        reset = 1'b0;
        slv1(0, 1, 0, 256, 0, 32, 1, 1, 32'h0, "A[0] cleared by reset");
        slv1(1, 1, 0, 652, 0, 32, 1, 1, 32'h0, "A[99] cleared by reset");
        start_run();
        wait_done();
        slv1(1, 1, 0, 276, 0, 32, 1, 1, 32'hFFFF_FFA1, "A[5] after rerun");

        repeat (3) @(negedge clock);
        check("scoreboard drained", sq.size(), 0);
        check("spurious slave outputs", spurious, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
